sync_fifo: RTL and testbench

//  Single-clock FIFO with first-word-fall-through (FWFT) or standard read mode.

---
 rtl/sync_fifo_pkg.sv | 31 +++
 rtl/sync_fifo_ram.sv | 52 +++++
 rtl/sync_fifo.sv | 165 ++++++++++++++++
 tb/tb_sync_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo slice: read-mode encoding, storage
// style hint, reset values and a constant-evaluable clog2.
package sync_fifo_pkg;

  // Read-side presentation mode.
  typedef enum logic {
    RD_STANDARD = 1'b0,
    RD_FWFT     = 1'b1
  } rd_mode_e;

  // Default ram_style attribute value for the storage array.
  localparam string RAM_STYLE_DEFAULT = "block";

  // Reset values of the status flags.
  localparam logic RST_FLAG_LOW = 1'b0;
  localparam logic RST_EMPTY    = 1'b1;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: one write port, one read port with
// a registered output. Only the read register is reset; the array is not.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter string       RAM_TYPE   = RAM_STYLE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  (* ram_style = RAM_TYPE *) logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next read-register value: load on a read, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Registered read output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through or standard read mode,
// optional occupancy count and write acknowledge.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 256,
  parameter int unsigned BYTE_WIDTH  = 1,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned FWFT        = 1,
  parameter int unsigned COUNT_ENA   = 1,
  parameter int unsigned COUNT_DELAY = 1,
  parameter int unsigned DATA_ZERO   = 0,
  parameter int unsigned ACK_ENA     = 1,
  parameter string       RAM_TYPE    = RAM_STYLE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [8*BYTE_WIDTH-1:0] wr_data,
  output logic                    wr_ack,
  output logic                    wr_full,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [8*BYTE_WIDTH-1:0] rd_data,
  output logic                    rd_empty,
  output logic [COUNT_WIDTH-1:0]  data_count
);

  localparam int unsigned AW      = clog2(FIFO_DEPTH);
  localparam int unsigned OW      = AW + 1;
  localparam int unsigned DW      = 8 * BYTE_WIDTH;
  localparam int unsigned CNT_MAX = (1 << COUNT_WIDTH) - 1;
  localparam rd_mode_e    RD_MODE = (FWFT != 0) ? RD_FWFT : RD_STANDARD;

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]          occ_q, occ_d;
  logic                   wr_full_q, wr_full_d;
  logic                   wr_ack_q, wr_ack_d;
  logic                   ram_valid_q, ram_valid_d;
  logic                   out_valid_q, out_valid_d;
  logic [DW-1:0]          out_data_q, out_data_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] cnt_dly_q, cnt_dly_d;

  logic          wr_acc;
  logic          pop;
  logic          ram_rd;
  logic          out_load;
  logic          mem_avail;
  logic [OW-1:0] staged;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] rd_data_raw;

  sync_fifo_ram #(
    .DEPTH      (FIFO_DEPTH),
    .WIDTH      (DW),
    .ADDR_WIDTH (AW),
    .RAM_TYPE   (RAM_TYPE)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  // Flow control: accepted write, pop, RAM read issue and prefetch transfer.
  // In FWFT mode the RAM read register and the output register form a
  // two-stage prefetch; words sitting in either stage still count as
  // occupancy, so the array only holds occ minus the staged words.
  always_comb begin
    wr_acc    = wr_en & ~wr_full_q;
    staged    = OW'(ram_valid_q) + OW'(out_valid_q);
    mem_avail = 1'b0;
    pop       = 1'b0;
    out_load  = 1'b0;
    ram_rd    = 1'b0;
    ram_valid_d = ram_valid_q;
    out_valid_d = out_valid_q;
    if (RD_MODE == RD_FWFT) begin
      mem_avail   = occ_q > staged;
      pop         = rd_en & out_valid_q;
      out_load    = ram_valid_q & (~out_valid_q | pop);
      ram_rd      = mem_avail & (~ram_valid_q | out_load);
      ram_valid_d = ram_rd | (ram_valid_q & ~out_load);
      out_valid_d = out_load | (out_valid_q & ~pop);
    end else begin
      pop         = rd_en & (occ_q != '0);
      ram_rd      = pop;
      ram_valid_d = pop;
      out_valid_d = 1'b0;
    end
  end

  // Pointers, occupancy, flags, ack and count next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d   = rd_ptr_q + AW'(ram_rd);
    occ_d      = occ_q + OW'(wr_acc) - OW'(pop);
    wr_full_d  = (occ_d == OW'(FIFO_DEPTH));
    wr_ack_d   = (ACK_ENA != 0) ? wr_acc : 1'b0;
    out_data_d = out_load ? ram_rd_data : out_data_q;
    cnt_d      = COUNT_WIDTH'(occ_d);
    if (32'(occ_d) > CNT_MAX) begin
      cnt_d = '1;
    end
    cnt_dly_d  = cnt_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      wr_full_q   <= RST_FLAG_LOW;
      wr_ack_q    <= RST_FLAG_LOW;
      ram_valid_q <= RST_FLAG_LOW;
      out_valid_q <= RST_FLAG_LOW;
      out_data_q  <= '0;
      cnt_q       <= '0;
      cnt_dly_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      wr_full_q   <= wr_full_d;
      wr_ack_q    <= wr_ack_d;
      ram_valid_q <= ram_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      cnt_dly_q   <= cnt_dly_d;
    end
  end

  // Output presentation for the selected read mode.
  always_comb begin
    if (RD_MODE == RD_FWFT) begin
      rd_valid    = out_valid_q;
      rd_empty    = ~out_valid_q;
      rd_data_raw = out_data_q;
    end else begin
      rd_valid    = ram_valid_q;
      rd_empty    = (occ_q == '0) ? RST_EMPTY : 1'b0;
      rd_data_raw = ram_rd_data;
    end
    rd_data = rd_data_raw;
    if ((DATA_ZERO != 0) && !rd_valid) begin
      rd_data = '0;
    end
    data_count = '0;
    if (COUNT_ENA != 0) begin
      data_count = (COUNT_DELAY != 0) ? cnt_dly_q : cnt_q;
    end
  end

  assign wr_full = wr_full_q;
  assign wr_ack  = wr_ack_q;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  logic       clk;
  logic       rstn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       wr_full;
  logic       rd_en;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic [7:0] data_count;

  int checks;
  int errors;

  sync_fifo #(
    .FIFO_DEPTH  (256),
    .BYTE_WIDTH  (1),
    .COUNT_WIDTH (8),
    .FWFT        (1),
    .COUNT_ENA   (1),
    .COUNT_DELAY (1),
    .DATA_ZERO   (0),
    .ACK_ENA     (1),
    .RAM_TYPE    ("block")
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .wr_full    (wr_full),
    .rd_en      (rd_en),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_empty   (rd_empty),
    .data_count (data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    tick(); tick();
    rstn = 1'b1;
    tick(); tick();
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_rd_empty got %b want 1", rd_empty); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full got %b want 0", wr_full); end
    checks++; if (data_count !== 8'd0) begin errors++; $display("FAIL reset_data_count got %0d want 0", data_count); end
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL reset_wr_ack got %b want 0", wr_ack); end
    checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL fill_ack[%0d] got %b want 1", i, wr_ack); end
      if (i == 254) begin
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL fill_not_full_255 got %b want 0", wr_full); end
      end
    end
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", wr_full); end
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL fill_drop_ack got %b want 0", wr_ack); end
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL fill_drop_full got %b want 1", wr_full); end
    tick(); tick();
    checks++; if (data_count !== 8'd255) begin errors++; $display("FAIL fill_count got %0d want 255", data_count); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'd0) begin errors++; $display("FAIL fill_head got v=%b d=%0d want v=1 d=0", rd_valid, rd_data); end
  endtask

  task automatic test_drain();
    rd_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        errors++; $display("FAIL drain[%0d] got v=%b d=%0d want v=1 d=%0d", i, rd_valid, rd_data, i);
      end
      tick();
    end
    rd_en = 1'b0;
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", rd_empty); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", rd_valid); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL drain_full got %b want 0", wr_full); end
    tick(); tick();
    checks++; if (data_count !== 8'd0) begin errors++; $display("FAIL drain_count got %0d want 0", data_count); end
  endtask

  task automatic test_stream();
    logic [7:0] wr_cnt;
    logic [7:0] exp_val;
    int pops;
    wr_cnt = '0; exp_val = '0; pops = 0;
    for (int c = 0; c < 4000; c++) begin
      wr_en   = (c % 2 == 0);
      wr_data = wr_cnt;
      rd_en   = 1'($urandom_range(0, 1));
      if (wr_en && !wr_full) wr_cnt = wr_cnt + 8'd1;
      if (rd_en && rd_valid) begin
        checks++;
        if (rd_data !== exp_val) begin
          errors++; $display("FAIL stream[%0d] got %0d want %0d", pops, rd_data, exp_val);
        end
        exp_val = exp_val + 8'd1;
        pops++;
      end
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick(); tick(); tick(); tick();
    rd_en = 1'b1;
    for (int k = 0; k < 300 && rd_valid; k++) begin
      checks++;
      if (rd_data !== exp_val) begin
        errors++; $display("FAIL stream_tail got %0d want %0d", rd_data, exp_val);
      end
      exp_val = exp_val + 8'd1;
      pops++;
      tick();
    end
    rd_en = 1'b0;
    checks++; if (exp_val !== wr_cnt) begin errors++; $display("FAIL stream_total popped_to %0d want %0d", exp_val, wr_cnt); end
    checks++; if (pops < 1000) begin errors++; $display("FAIL stream_pops got %0d want >=1000", pops); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %b want 1", rd_empty); end
  endtask

  task automatic test_full_rw();
    wr_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick();
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL frw_full got %b want 1", wr_full); end
    wr_en = 1'b1; wr_data = 8'h55; rd_en = 1'b1;
    checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL frw_head got %0d want 0", rd_data); end
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL frw_full_after got %b want 0", wr_full); end
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL frw_ack got %b want 0", wr_ack); end
    checks++; if (rd_data !== 8'd1) begin errors++; $display("FAIL frw_next got %0d want 1", rd_data); end
    rd_en = 1'b1;
    for (int i = 1; i < 256; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        errors++; $display("FAIL frw_drain[%0d] got v=%b d=%0d want v=1 d=%0d", i, rd_valid, rd_data, i);
      end
      tick();
    end
    rd_en = 1'b0;
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL frw_empty got %b want 1", rd_empty); end
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick(); tick();
    checks++; if (data_count !== 8'd10) begin errors++; $display("FAIL rmid_count got %0d want 10", data_count); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (rd_empty !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_rd got empty=%b valid=%b want 1 0", rd_empty, rd_valid); end
    checks++; if (wr_full !== 1'b0 || wr_ack !== 1'b0) begin errors++; $display("FAIL rmid_wr got full=%b ack=%b want 0 0", wr_full, wr_ack); end
    checks++; if (rd_data !== 8'd0 || data_count !== 8'd0) begin errors++; $display("FAIL rmid_data got d=%0d cnt=%0d want 0 0", rd_data, data_count); end
    tick(); tick();
    rstn = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'hC3;
    tick();
    wr_en = 1'b0;
    checks++; if (wr_ack !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_n0 got ack=%b valid=%b want 1 0", wr_ack, rd_valid); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_n1 valid got %b want 0", rd_valid); end
    tick();
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin errors++; $display("FAIL rmid_n2 got v=%b d=%0h want v=1 d=c3", rd_valid, rd_data); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL rmid_final_empty got %b want 1", rd_empty); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_rw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
